circular_right_unshift_unit: RTL and testbench
==============================================

CIRCULAR_RIGHT_UNSHIFT_UNIT -- requirements
Module: circular_right_unshift_unit

Interface
REQ-001 Parameters SHALL be, one per line: SEGS, 16, segment count; SEG_W, 64, recovered segment width; PAD_W, 192, padded/rotated segment width; STEP, 12, per-index rotation step in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  data_shifted and k valid.
REQ-005 in_ready  output  1  block can accept a block; high only in IDLE.
REQ-006 data_shifted  input  SEGS*PAD_W (3072)  16 rotated 192-bit segments, segment n at [n*192 +: 192].
REQ-007 k  input  4  shift pattern index 0..15, sampled with data_shifted.
REQ-008 out_valid  output  1  data_out and pad_err valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 data_out  output  SEGS*SEG_W (1024)  recovered segments, segment n at [n*64 +: 64].
REQ-011 pad_err  output  1  sticky flag: a recovered segment had nonzero upper 128 bits.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 In IDLE with in_valid=1, the block SHALL register data_shifted and k, clear data_out and pad_err, set n=0 and enter BUSY at the same edge.
REQ-014 In each BUSY cycle, the block SHALL rotate captured segment n right by amt(n)=(k*n*STEP) mod PAD_W, write bits [63:0] of the result to data_out[n*64 +: 64], then increment n.
REQ-015 A rotation with amt=0 SHALL pass the segment through unchanged.
REQ-016 amt SHALL be computed without truncation (k*n*12 <= 2700, at least 12 bits) or kept as an accumulator stepped by k*12 with mod-192 wrap; both forms SHALL give identical results.
REQ-017 After the edge that processes n=15, the FSM SHALL enter DONE and raise out_valid; out_valid therefore rises 16 cycles after the accept edge.
REQ-018 In DONE, data_out, pad_err and out_valid SHALL hold stable until out_ready=1; at that edge the FSM SHALL return to IDLE and drop out_valid.
REQ-019 in_valid SHALL be ignored in BUSY and DONE; no new block is accepted in the cycle out_valid drops, only from the following IDLE cycle.
REQ-020 data_out SHALL keep its last value in IDLE until the next accept.

Reset
REQ-021 While rst=1 the block SHALL be in IDLE with in_ready=1 (from the first cycle after rst deasserts), out_valid=0, data_out=0, pad_err=0, n=0, captured data=0.
REQ-022 rst asserted in BUSY or DONE SHALL abort the operation at that edge, discard the captured block and suppress out_valid.
REQ-023 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-024 Macro UNSHIFT_PAD_CHECK_EN defined: in each BUSY cycle, if bits [191:64] of the rotated segment are nonzero, pad_err SHALL set and stay set until the next accept or reset.
REQ-025 Macro UNSHIFT_PAD_CHECK_EN undefined: the check logic SHALL be absent and pad_err SHALL be tied to 0.

Verification
REQ-026 k=0, segment n = {128'b0, 64'h0123_4567_89AB_CDE0 + n} -> data_out segment n equals the low word, pad_err=0, out_valid 16 cycles after accept.
REQ-027 Round trip: segment n = 64'hA5A5_A5A5_A5A5_A5A5 ^ n, padded and rotated left by (5*n*12) mod 192 -> all 16 segments recovered exactly, pad_err=0.
REQ-028 k=15: segment 15 (amt=2700 mod 192=12) holding {128'b0, 64'h8000_0000_0000_0001} rotated left 12 -> data_out[1023:960]=64'h8000_0000_0000_0001.
REQ-029 k=0, bit 100 of segment 3 set -> pad_err=1 with UNSHIFT_PAD_CHECK_EN, pad_err=0 without; data_out unchanged in both cases.
REQ-030 rst=1 in the 8th BUSY cycle -> next cycle IDLE, in_ready=1, out_valid=0, data_out=0, pad_err=0.
REQ-031 out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid, data_out and pad_err held, in_ready=0, no capture; out_ready=1 -> IDLE on the next edge.

Source files
------------

// File: rtl/circular_right_unshift_unit.sv
// circular_right_unshift_unit
//
// Recovers SEGS segments of SEG_W bits from a block of SEGS padded segments
// of PAD_W bits, each of which was rotated left by (k*n*STEP) mod PAD_W.
// One segment is un-rotated per cycle. The result is then held until the
// consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high. in_ready is high only in IDLE. out_valid is high only in
// DONE, and data_out/pad_err are held stable while out_valid is high.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_valid     data_shifted and k are valid
//   in_ready     block can accept a new input block (IDLE)
//   data_shifted SEGS rotated PAD_W-bit segments, segment n at [n*PAD_W +: PAD_W]
//   k            shift pattern index
//   out_valid    data_out and pad_err are valid (DONE)
//   out_ready    consumer accepts the result
//   data_out     recovered segments, segment n at [n*SEG_W +: SEG_W]
//   pad_err      sticky: some recovered segment had nonzero padding bits
//   dbg_state    current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Configuration macro: UNSHIFT_PAD_CHECK_EN
//   defined   -> padding bits of every un-rotated segment are checked and
//                pad_err is set when any of them is nonzero
//   undefined -> no check logic, pad_err is tied to 0

module circular_right_unshift_unit #(
  parameter int SEGS  = 16,
  parameter int SEG_W = 64,
  parameter int PAD_W = 192,
  parameter int STEP  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEGS*PAD_W-1:0]   data_shifted,
  input  logic [3:0]              k,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEGS*SEG_W-1:0]   data_out,
  output logic                    pad_err,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              n_q;
  logic [3:0]              k_q;
  logic [SEGS*PAD_W-1:0]   data_q;
  logic [SEGS*SEG_W-1:0]   data_out_q;

  // Full product k*n*STEP is at most 15*15*12 = 2700, so 12 bits never
  // truncate; the mod then folds it into the segment width.
  logic [11:0]             amt_full;
  logic [7:0]              amt;
  logic [PAD_W-1:0]        seg;
  logic [2*PAD_W-1:0]      seg_dbl;

  assign amt_full = 12'(k_q) * 12'(n_q) * 12'(STEP);
  assign amt      = 8'(amt_full % 12'(PAD_W));
  assign seg      = data_q[n_q*PAD_W +: PAD_W];
  // Rotate right by shifting a doubled copy; amt=0 passes the segment through.
  assign seg_dbl  = {seg, seg};

`ifdef UNSHIFT_PAD_CHECK_EN
  logic [PAD_W-1:0] rot;
  logic             pad_err_q;
  assign rot = PAD_W'(seg_dbl >> amt);

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_err_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      pad_err_q <= 1'b0;
    end else if (state_q == BUSY && (rot[PAD_W-1:SEG_W] != '0)) begin
      pad_err_q <= 1'b1;
    end
  end

  assign pad_err = pad_err_q;

  logic [SEG_W-1:0] rot_lo;
  assign rot_lo = rot[SEG_W-1:0];
`else
  logic [SEG_W-1:0] rot_lo;
  assign rot_lo  = SEG_W'(seg_dbl >> amt);
  assign pad_err = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (n_q == 4'(SEGS - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      data_q     <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= data_shifted;
            k_q        <= k;
            data_out_q <= '0;
            n_q        <= '0;
          end
        end
        BUSY: begin
          data_out_q[n_q*SEG_W +: SEG_W] <= rot_lo;
          // Wraps back to 0 after the last segment.
          n_q <= n_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = data_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_circular_right_unshift_unit.sv
module tb_circular_right_unshift_unit;

  localparam int SEGS  = 16;
  localparam int SEG_W = 64;
  localparam int PAD_W = 192;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [SEGS*PAD_W-1:0] data_shifted;
  logic [3:0]            k;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEGS*SEG_W-1:0] data_out;
  logic                  pad_err;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SEG_W-1:0] exp_q[$];

`ifdef UNSHIFT_PAD_CHECK_EN
  localparam logic PAD_EXP = 1'b1;
`else
  localparam logic PAD_EXP = 1'b0;
`endif

  circular_right_unshift_unit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_shifted (data_shifted),
    .k            (k),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .pad_err      (pad_err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [SEG_W-1:0] obs,
                       input logic [SEG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PAD_W-1:0] rotl(input logic [PAD_W-1:0] v, input int a);
    if (a == 0) return v;
    return (v << a) | (v >> (PAD_W - a));
  endfunction

  // Driver: present one block for a single accept edge.
  task automatic send_block(input logic [SEGS*PAD_W-1:0] d, input logic [3:0] kk);
    data_shifted = d;
    k            = kk;
    in_valid     = 1'b1;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid after an accept; checks the 16-cycle latency.
  task automatic wait_done(input string tag);
    int cycles;
    cycles = 1;
    while (!out_valid && cycles < 100) begin
      step();
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'd17);
  endtask

  // Scoreboard: compare every segment against the expected queue.
  task automatic compare_segments(input string tag);
    logic [SEG_W-1:0] e;
    for (int n = 0; n < SEGS; n++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_exp_q_empty"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_seg%0d", tag, n), data_out[n*SEG_W +: SEG_W], e);
      end
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [SEGS*PAD_W-1:0] d;
    logic [SEG_W-1:0]      w;
    logic [SEG_W-1:0]      seg3_lo;

    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    k            = '0;
    data_shifted = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out_zero", 64'(|data_out), 64'd0);
    check("rst_pad_err", 64'(pad_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // k=0: straight pass-through of the low words
    d = '0;
    for (int n = 0; n < SEGS; n++) begin
      w = 64'h0123_4567_89AB_CDE0 + 64'(n);
      d[n*PAD_W +: PAD_W] = {128'b0, w};
      exp_q.push_back(w);
    end
    send_block(d, 4'd0);
    check("k0_busy_in_ready", 64'(in_ready), 64'd0);
    wait_done("k0");
    compare_segments("k0");
    check("k0_pad_err", 64'(pad_err), 64'd0);
    release_result("k0");

    // Round trip with k=5
    d = '0;
    for (int n = 0; n < SEGS; n++) begin
      w = 64'hA5A5_A5A5_A5A5_A5A5 ^ 64'(n);
      d[n*PAD_W +: PAD_W] = rotl({128'b0, w}, (5 * n * 12) % 192);
      exp_q.push_back(w);
    end
    send_block(d, 4'd5);
    wait_done("k5");
    compare_segments("k5");
    check("k5_pad_err", 64'(pad_err), 64'd0);
    release_result("k5");

    // k=15: segment 15 rotates by 2700 mod 192 = 12
    d = '0;
    d[15*PAD_W +: PAD_W] = rotl({128'b0, 64'h8000_0000_0000_0001}, 12);
    send_block(d, 4'd15);
    wait_done("k15");
    check("k15_seg15", data_out[1023:960], 64'h8000_0000_0000_0001);
    check("k15_seg0", data_out[63:0], 64'h0);
    check("k15_pad_err", 64'(pad_err), 64'd0);
    release_result("k15");

    // k=0 with bit 100 set in segment 3, then hold in DONE for 5 cycles
    seg3_lo = 64'h0000_0000_0000_1234;
    d = '0;
    d[3*PAD_W +: PAD_W] = {128'b0, seg3_lo};
    d[3*PAD_W + 100] = 1'b1;
    send_block(d, 4'd0);
    wait_done("pad");
    check("pad_seg3", data_out[3*SEG_W +: SEG_W], seg3_lo);
    check("pad_err_flag", 64'(pad_err), 64'(PAD_EXP));
    data_shifted = {SEGS*PAD_W{1'b1}};
    k            = 4'd7;
    in_valid     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("hold%0d_out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("hold%0d_seg3", c), data_out[3*SEG_W +: SEG_W], seg3_lo);
      check($sformatf("hold%0d_seg0", c), data_out[SEG_W-1:0], 64'h0);
      check($sformatf("hold%0d_pad_err", c), 64'(pad_err), 64'(PAD_EXP));
    end
    in_valid = 1'b0;
    release_result("hold");
    check("idle_keeps_seg3", data_out[3*SEG_W +: SEG_W], seg3_lo);
    step();
    check("idle_no_capture_state", 64'(dbg_state), 64'd0);

    // Reset in the 8th BUSY cycle aborts the block
    d = '0;
    for (int n = 0; n < SEGS; n++) d[n*PAD_W +: PAD_W] = {128'b0, 64'hFFFF_0000_FFFF_0000};
    send_block(d, 4'd0);
    for (int c = 0; c < 7; c++) step();
    check("abort_busy_before_rst", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_data_out_zero", 64'(|data_out), 64'd0);
    check("abort_pad_err", 64'(pad_err), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (out_valid) seen = 1;
      end
      check("abort_no_out_valid", 64'(seen), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
